// File: rtl/ballot_controller.sv
// ballot_controller: synchronises and debounces four candidate buttons and
// enforces one registered, one-hot vote pulse per officer-armed ballot.
`default_nettype none

module ballot_controller #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int LED_HOLD_CYCLES = 8,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic arm,
    input  logic button1,
    input  logic button2,
    input  logic button3,
    input  logic button4,
    output logic vote1,
    output logic vote2,
    output logic vote3,
    output logic vote4,
    output logic led1,
    output logic led2,
    output logic led3,
    output logic led4,
    output logic ready,
    output logic timeout
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int HW = $clog2(LED_HOLD_CYCLES) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] H_LAST = HW'(LED_HOLD_CYCLES - 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        QUAL    = 3'd2,
        CAST    = 3'd3,
        ACK     = 3'd4,
        RELEASE = 3'd5
    } state_t;

    state_t        state;
    logic [3:0]    s1;
    logic [3:0]    s2;
    logic [3:0]    cand;
    logic [3:0]    vote;
    logic [3:0]    led;
    logic [DW-1:0] dcnt;
    logic [HW-1:0] hcnt;
    logic [TW-1:0] tcnt;

    logic [3:0]    buttons;
    logic          sel;
    logic [DW-1:0] dnext;
    logic          cast_ok;
    logic          expired;

    assign buttons = {button4, button3, button2, button1};
    assign sel     = (s2 != 4'b0000) && ((s2 & (s2 - 4'd1)) == 4'b0000);
    assign dnext   = dcnt + DW'(1);

    // The ARMED cycle that latched the candidate already counts as one stable
    // cycle, so the incremented count is compared to cast on time.
    assign cast_ok = (s2 == cand) && (dnext == D_LAST);
    assign expired = (tcnt == T_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            s1      <= 4'b0000;
            s2      <= 4'b0000;
            cand    <= 4'b0000;
            vote    <= 4'b0000;
            led     <= 4'b0000;
            dcnt    <= '0;
            hcnt    <= '0;
            tcnt    <= '0;
            ready   <= 1'b0;
            timeout <= 1'b0;
        end else begin
            s1      <= buttons;
            s2      <= s1;
            vote    <= 4'b0000;
            timeout <= 1'b0;

            case (state)
                IDLE: begin
                    tcnt <= '0;
                    led  <= 4'b0000;
                    if (arm) begin
                        state <= ARMED;
                        ready <= 1'b1;
                    end
                end

                ARMED: begin
                    tcnt <= tcnt + TW'(1);
                    if (expired) begin
                        timeout <= 1'b1;
                        ready   <= 1'b0;
                        state   <= IDLE;
                    end else if (sel) begin
                        cand  <= s2;
                        dcnt  <= '0;
                        state <= QUAL;
                    end
                end

                QUAL: begin
                    tcnt <= tcnt + TW'(1);
                    dcnt <= dnext;
                    // A completed debounce beats an expiry landing on the same edge.
                    if (cast_ok) begin
                        vote  <= cand;
                        ready <= 1'b0;
                        state <= CAST;
                    end else if (expired) begin
                        timeout <= 1'b1;
                        ready   <= 1'b0;
                        state   <= IDLE;
                    end else if (s2 != cand) begin
                        dcnt  <= '0;
                        state <= ARMED;
                    end
                end

                CAST: begin
                    hcnt  <= '0;
                    led   <= cand;
                    state <= ACK;
                end

                ACK: begin
                    hcnt <= hcnt + HW'(1);
                    if (hcnt == H_LAST) begin
                        led   <= 4'b0000;
                        state <= RELEASE;
                    end
                end

                RELEASE: begin
                    if (s2 == 4'b0000) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign vote1 = vote[0];
    assign vote2 = vote[1];
    assign vote3 = vote[2];
    assign vote4 = vote[3];
    assign led1  = led[0];
    assign led2  = led[1];
    assign led3  = led[2];
    assign led4  = led[3];

endmodule

`default_nettype wire

// File: tb/tb_ballot_controller.sv
// Directed bench for ballot_controller with DEBOUNCE=4, LED_HOLD=3, TIMEOUT=20.
`default_nettype none

module tb_ballot_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic arm = 1'b0;
    logic button1 = 1'b0;
    logic button2 = 1'b0;
    logic button3 = 1'b0;
    logic button4 = 1'b0;
    logic vote1, vote2, vote3, vote4;
    logic led1, led2, led3, led4;
    logic ready, timeout;

    logic [3:0] vote_v;
    logic [3:0] led_v;
    assign vote_v = {vote4, vote3, vote2, vote1};
    assign led_v  = {led4, led3, led2, led1};

    int errors = 0;
    int checks = 0;
    int vote_cnt [4];
    int to_cnt = 0;
    int multi_cnt = 0;
    int base [4];
    int base_to;

    ballot_controller #(
        .DEBOUNCE_CYCLES(4),
        .LED_HOLD_CYCLES(3),
        .TIMEOUT_CYCLES (20)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .arm    (arm),
        .button1(button1),
        .button2(button2),
        .button3(button3),
        .button4(button4),
        .vote1  (vote1),
        .vote2  (vote2),
        .vote3  (vote3),
        .vote4  (vote4),
        .led1   (led1),
        .led2   (led2),
        .led3   (led3),
        .led4   (led4),
        .ready  (ready),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 4; i++) vote_cnt[i] = 0;
    end

    // Pulse counters sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (vote_v[i] === 1'b1) vote_cnt[i] = vote_cnt[i] + 1;
        end
        if (timeout === 1'b1) to_cnt = to_cnt + 1;
        if ($countones(vote_v) > 1) multi_cnt = multi_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic snap();
        for (int i = 0; i < 4; i++) base[i] = vote_cnt[i];
        base_to = to_cnt;
    endtask

    task automatic arm_ballot(input string tag);
        arm = 1'b1;
        tick(1);
        arm = 1'b0;
        chk(tag, {31'd0, ready}, 32'd1);
    endtask

    initial begin
        // Reset state
        tick(2);
        chk("rst_outputs", {22'd0, vote_v, led_v, ready, timeout}, 32'd0);
        rst = 1'b0;
        tick(2);
        chk("idle_ready", {31'd0, ready}, 32'd0);

        // Single vote on button2: first sample at N, vote after N+5
        snap();
        arm_ballot("t1_ready");
        button2 = 1'b1;
        tick(5);
        chk("t1_no_early_vote", {28'd0, vote_v}, 32'd0);
        chk("t1_ready_qual", {31'd0, ready}, 32'd1);
        tick(1);
        chk("t1_vote2", {28'd0, vote_v}, 32'h2);
        chk("t1_ready_fall", {31'd0, ready}, 32'd0);
        tick(1);
        chk("t1_vote_done", {28'd0, vote_v}, 32'd0);
        chk("t1_led2_c1", {28'd0, led_v}, 32'h2);
        tick(2);
        chk("t1_led2_c3", {28'd0, led_v}, 32'h2);
        tick(1);
        chk("t1_led_off", {28'd0, led_v}, 32'd0);
        button2 = 1'b0;
        tick(6);
        chk("t1_vote2_once", vote_cnt[1] - base[1], 32'd1);
        chk("t1_others", vote_cnt[0] + vote_cnt[2] + vote_cnt[3] - base[0] - base[2] - base[3], 32'd0);
        chk("t1_no_timeout", to_cnt - base_to, 32'd0);
        chk("t1_idle_ready", {31'd0, ready}, 32'd0);

        // Bounce on button3, then stable hold
        snap();
        arm_ballot("t2_ready");
        repeat (3) begin
            button3 = 1'b1;
            tick(2);
            button3 = 1'b0;
            tick(2);
        end
        chk("t2_no_vote_bounce", vote_cnt[2] - base[2], 32'd0);
        button3 = 1'b1;
        tick(5);
        chk("t2_no_early_vote", {28'd0, vote_v}, 32'd0);
        tick(1);
        chk("t2_vote3", {28'd0, vote_v}, 32'h4);
        button3 = 1'b0;
        tick(8);
        chk("t2_vote3_once", vote_cnt[2] - base[2], 32'd1);
        chk("t2_no_timeout", to_cnt - base_to, 32'd0);

        // Simultaneous button1+button4: no vote, timeout 20 edges after arm
        snap();
        arm_ballot("t3_ready");
        button1 = 1'b1;
        button4 = 1'b1;
        tick(10);
        chk("t3_ready_held", {31'd0, ready}, 32'd1);
        button1 = 1'b0;
        button4 = 1'b0;
        tick(9);
        chk("t3_no_early_to", {31'd0, timeout}, 32'd0);
        chk("t3_ready_19", {31'd0, ready}, 32'd1);
        tick(1);
        chk("t3_timeout", {31'd0, timeout}, 32'd1);
        chk("t3_ready_drop", {31'd0, ready}, 32'd0);
        tick(1);
        chk("t3_timeout_pulse", {31'd0, timeout}, 32'd0);
        chk("t3_no_votes", vote_cnt[0] + vote_cnt[1] + vote_cnt[2] + vote_cnt[3]
                           - base[0] - base[1] - base[2] - base[3], 32'd0);
        chk("t3_one_timeout", to_cnt - base_to, 32'd1);

        // Button1 held across ballots
        snap();
        arm_ballot("t4_ready");
        button1 = 1'b1;
        tick(6);
        chk("t4_vote1", {28'd0, vote_v}, 32'h1);
        arm = 1'b1;
        tick(1);
        arm = 1'b0;
        tick(8);
        chk("t4_not_armed_held", {31'd0, ready}, 32'd0);
        arm = 1'b1;
        tick(1);
        arm = 1'b0;
        tick(1);
        chk("t4_still_not_armed", {31'd0, ready}, 32'd0);
        button1 = 1'b0;
        tick(5);
        chk("t4_idle_after_rel", {31'd0, ready}, 32'd0);
        chk("t4_vote1_once", vote_cnt[0] - base[0], 32'd1);

        // Reset during QUAL
        snap();
        arm_ballot("t5_ready");
        button1 = 1'b1;
        tick(4);
        rst = 1'b1;
        tick(1);
        chk("t5_rst_outputs", {22'd0, vote_v, led_v, ready, timeout}, 32'd0);
        rst = 1'b0;
        tick(1);
        chk("t5_no_vote_slot", {28'd0, vote_v}, 32'd0);
        button1 = 1'b0;
        tick(6);
        chk("t5_no_vote", vote_cnt[0] - base[0], 32'd0);
        chk("t5_ready_low", {31'd0, ready}, 32'd0);

        // Reset during ACK
        arm_ballot("t6_ready");
        button2 = 1'b1;
        tick(6);
        chk("t6_vote2", {28'd0, vote_v}, 32'h2);
        tick(1);
        chk("t6_led2", {28'd0, led_v}, 32'h2);
        rst = 1'b1;
        tick(1);
        chk("t6_rst_outputs", {22'd0, vote_v, led_v, ready, timeout}, 32'd0);
        rst = 1'b0;
        button2 = 1'b0;
        tick(3);
        chk("t6_after_rst", {22'd0, vote_v, led_v, ready, timeout}, 32'd0);

        // Cast and expiry on the same edge: cast wins
        snap();
        arm_ballot("t7_ready");
        tick(14);
        button4 = 1'b1;
        tick(6);
        chk("t7_vote4", {28'd0, vote_v}, 32'h8);
        chk("t7_no_timeout", {31'd0, timeout}, 32'd0);
        tick(1);
        chk("t7_no_late_to", {31'd0, timeout}, 32'd0);
        button4 = 1'b0;
        tick(8);
        chk("t7_to_count", to_cnt - base_to, 32'd0);

        // Pressed one cycle later: expiry wins
        snap();
        arm_ballot("t8_ready");
        tick(15);
        button4 = 1'b1;
        tick(5);
        chk("t8_timeout", {31'd0, timeout}, 32'd1);
        chk("t8_no_vote_20", {28'd0, vote_v}, 32'd0);
        tick(1);
        chk("t8_no_vote_21", {28'd0, vote_v}, 32'd0);
        button4 = 1'b0;
        tick(5);
        chk("t8_vote4_none", vote_cnt[3] - base[3], 32'd0);
        chk("t8_to_count", to_cnt - base_to, 32'd1);

        chk("onehot_votes", multi_cnt, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ballot_controller.md
# ballot_controller

Input-conditioning stage that sits directly upstream of the vote tally counter. It synchronises and debounces the four raw candidate push-buttons and enforces one vote per ballot armed by the presiding officer. Each accepted vote leaves the block as exactly one single-cycle, one-hot pulse on vote1..vote4, which drives the tally's button1..button4 inputs. It also owns the voter-acknowledge LEDs and the ballot timeout.

## Interface
- DEBOUNCE_CYCLES, 16: consecutive cycles a single synchronised button must stay high, in QUAL, before the vote is cast (≥2).
- LED_HOLD_CYCLES, 8: cycles the acknowledge LED stays lit after a cast (≥1).
- TIMEOUT_CYCLES, 1024: cycles allowed from arm acceptance to cast before the ballot is voided (> DEBOUNCE_CYCLES+1).
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- arm  in  1  officer enable; sampled only in IDLE; a level high for one or more cycles arms one ballot.
- button1..button4  in  1 each  raw, asynchronous candidate buttons, active high.
- vote1..vote4  out  1 each  one-cycle vote pulse, at most one high in any cycle.
- led1..led4  out  1 each  acknowledge LED for the candidate just voted.
- ready  out  1  high while a ballot is armed and open (ARMED or QUAL).
- timeout  out  1  one-cycle pulse when an armed ballot expires unvoted.

## Operation
- Each button passes through a 2-flop synchroniser (s1→s2). The FSM uses only the s2 values. Let "sel" mean exactly one s2 bit is high.
- States: IDLE, ARMED, QUAL, CAST, ACK, RELEASE.
- IDLE: go to ARMED if arm=1. The timeout counter tcnt clears to 0.
- ARMED: tcnt increments each cycle.
  - If sel: latch the candidate index, clear dcnt, go to QUAL.
  - If two or more s2 bits are high: stay in ARMED. No vote is cast.
- QUAL: tcnt and dcnt increment each cycle.
  - If s2 ≠ the latched one-hot pattern (released, changed, or a second button added): go to ARMED with dcnt=0.
  - Else, if dcnt = DEBOUNCE_CYCLES-1: go to CAST.
- CAST, one cycle: vote_k=1 for the latched k. Go to ACK with hold counter hcnt=0.
- ACK: led_k=1. Go to RELEASE when hcnt = LED_HOLD_CYCLES-1.
- RELEASE: wait until all s2 bits are 0, then go to IDLE. This stops a held button from voting again on the next ballot.
- Timeout: in ARMED or QUAL, tcnt = TIMEOUT_CYCLES-1 gives a timeout pulse and a transition to IDLE.
  - Precedence: if the CAST condition and the timeout condition are true in the same cycle, CAST wins and no timeout pulse is issued.
- arm is ignored outside IDLE. An arm held continuously re-arms immediately after RELEASE→IDLE; this is intended.
- Counters are sized as clog2(max parameter value)+1 bits and never wrap, because each is compared and cleared before overflow.

## Timing
- Reset values: vote1..4=0, led1..4=0, ready=0, timeout=0, state=IDLE, synchronisers=0, all counters=0.
- rst=1 in any state takes effect on the next edge. An in-flight QUAL or ACK is abandoned, no vote pulse is emitted, and LEDs clear.
- All outputs are registered (Moore).
- ready rises the edge after arm is sampled high in IDLE.
- Latency: raw button first sampled high at edge N, and held steady.
  - s2 is high after edge N+1.
  - QUAL is entered at edge N+2.
  - CAST is entered at edge N+1+DEBOUNCE_CYCLES, so vote_k is high for the single cycle following that edge.
- led_k rises one edge after the vote pulse and stays high LED_HOLD_CYCLES cycles. ready falls at the CAST edge.
- A glitch shorter than DEBOUNCE_CYCLES after synchronisation never produces a vote.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, LED_HOLD_CYCLES=3, TIMEOUT_CYCLES=20.

- Single vote: pulse arm, hold button2 high 10 cycles, release. Required: exactly one vote2 pulse 5 edges after the first sample, led2 high 3 cycles, then IDLE. vote1/3/4 and timeout stay 0.
- Bounce: button3 toggles every 2 cycles for 12 cycles, then holds high. Required: no vote during toggling, one vote3 after the stable hold. Counter restarts on each drop.
- Simultaneous press: button1 and button4 high together for 10 cycles. Required: no vote, ready stays 1, and timeout pulses at 20 cycles after arm if nothing else is pressed.
- Held across ballots: cast a vote with button1 held, keep it held, pulse arm again. Required: second ballot not armed until button1 releases, and only one vote1 total while held.
- Reset mid-operation: assert rst in QUAL and, separately, during ACK. Required: all outputs 0 next edge, no vote pulse, state IDLE, and ready=0 until re-armed.
- Timeout versus cast boundary: arm, then press button4 so that CAST and tcnt=19 coincide. Required: vote4 pulses and timeout stays 0. Pressed one cycle later: timeout pulses, no vote.
